vie_fetch_stage: RTL

//  Instruction-fetch stage (pre-IF + IF) of the vie 5-stage MIPS pipeline; feeds vie_id_stage via fsbus_o.

---
 rtl/vie_fetch_stage_if.sv | 18 +
 rtl/vie_fetch_stage.sv | 98 +++++++++
 2 files changed

// File: rtl/vie_fetch_stage_if.sv
// rtl/vie_fetch_stage_if.sv - fetch stage bus bundle: decode handshake, branch bus, inst SRAM port, fsbus
// VIE_FS_ADEL_EN widens fsbus_o by one bit (fs_adel at the MSB).
interface vie_fetch_stage_if;
`ifdef VIE_FS_ADEL_EN
  localparam int FSBUS_W = 66;
`else
  localparam int FSBUS_W = 65;
`endif

  logic               ds_allowin;
  logic [32:0]        brbus_i;
  logic [31:0]        ifc_inst_i;
  logic [68:0]        inst_ifc_o;
  logic [FSBUS_W-1:0] fsbus_o;

  modport master (input ds_allowin, brbus_i, ifc_inst_i, output inst_ifc_o, fsbus_o);
  modport slave  (output ds_allowin, brbus_i, ifc_inst_i, input inst_ifc_o, fsbus_o);
endinterface

// File: rtl/vie_fetch_stage.sv
// rtl/vie_fetch_stage.sv - vie pipeline pre-IF/IF stage: next-PC, inst SRAM request, stall buffer, branch redirect
// Optional VIE_FS_ADEL_EN: flags misaligned fetch PCs and suppresses their SRAM access.
module vie_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic               clock,
  input  logic               reset,
  vie_fetch_stage_if.master  bus
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;
  logic        br_pending;
  logic [31:0] br_pend_target;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] nextpc;
  logic [31:0] raw_inst;
  logic [31:0] fs_inst;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_to_ds_valid;
  logic        to_fs_valid;
  logic        fetch_go;
  logic        transfer;
  logic        en;

  assign br_taken       = bus.brbus_i[32];
  assign br_target      = bus.brbus_i[31:0];
  assign fs_ready_go    = fs_valid;
  assign fs_allowin     = !fs_valid | (fs_ready_go & bus.ds_allowin);
  assign fs_to_ds_valid = fs_valid & fs_ready_go;
  assign transfer       = fs_to_ds_valid & bus.ds_allowin;
  assign to_fs_valid    = !reset;
  assign fetch_go       = to_fs_valid & fs_allowin;

  // A branch seen this cycle beats one remembered from a stall.
  always_comb begin
    nextpc = fs_pc + 32'd4;
    if (br_taken)
      nextpc = br_target;
    else if (br_pending)
      nextpc = br_pend_target;
  end

  assign raw_inst = inst_buf_valid ? inst_buf : bus.ifc_inst_i;

`ifdef VIE_FS_ADEL_EN
  logic fs_adel;
  assign fs_adel     = fs_valid & (fs_pc[1:0] != 2'b00);
  assign en          = fetch_go & (nextpc[1:0] == 2'b00);
  assign fs_inst     = (fs_pc[1:0] != 2'b00) ? 32'h0 : raw_inst;
  assign bus.fsbus_o = {fs_adel, fs_to_ds_valid, fs_pc, fs_inst};
`else
  assign en          = fetch_go;
  assign fs_inst     = raw_inst;
  assign bus.fsbus_o = {fs_to_ds_valid, fs_pc, fs_inst};
`endif

  assign bus.inst_ifc_o = {en, 4'h0, nextpc, 32'h0};

  always_ff @(posedge clock) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - 32'd4;
      inst_buf       <= 32'h0;
      inst_buf_valid <= 1'b0;
      br_pending     <= 1'b0;
      br_pend_target <= 32'h0;
    end else begin
      if (fetch_go) begin
        fs_valid <= 1'b1;
        fs_pc    <= nextpc;
      end else if (transfer) begin
        fs_valid <= 1'b0;
      end

      // SRAM data is only valid for one cycle, so hold it while decode stalls.
      if (transfer) begin
        inst_buf_valid <= 1'b0;
      end else if (fs_valid && !inst_buf_valid && !bus.ds_allowin) begin
        inst_buf       <= bus.ifc_inst_i;
        inst_buf_valid <= 1'b1;
      end

      if (br_taken && !fetch_go) begin
        br_pending     <= 1'b1;
        br_pend_target <= br_target;
      end else if (fetch_go) begin
        br_pending <= 1'b0;
      end
    end
  end

endmodule
